// File: rtl/riscv_pkg.sv
// riscv_pkg: register-file widths and the writeback request type shared across the integer pipeline
package riscv_pkg;

    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous circular-buffer FIFO of writeback requests
module wb_fifo
    import riscv_pkg::*;
#(
    parameter type T     = wb_req_t,
    parameter int  DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;

    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and LSU results onto the register-file write port and tracks pending loads
module reg_writeback
    import riscv_pkg::*;
#(
    parameter int REG_COUNT      = NUM_REGS,
    parameter int WORD_SIZE      = XLEN,
    parameter int LSU_FIFO_DEPTH = 2,
    localparam int RA_W          = $clog2(REG_COUNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alu_valid_i,
    input  logic [RA_W-1:0]      alu_rd_i,
    input  logic [WORD_SIZE-1:0] alu_data_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [RA_W-1:0]      lsu_rd_i,
    input  logic [WORD_SIZE-1:0] lsu_data_i,
    input  logic                 issue_load_i,
    input  logic [RA_W-1:0]      issue_rd_i,
    output logic [REG_COUNT-1:0] busy_o,
    output logic                 reg_write_o,
    output logic [RA_W-1:0]      write_reg_o,
    output logic [WORD_SIZE-1:0] write_data_o
);

    typedef struct packed {
        logic [RA_W-1:0]      rd;
        logic [WORD_SIZE-1:0] data;
    } req_t;

    req_t                 lsu_req;
    req_t                 head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 sel_valid;
    logic [RA_W-1:0]      sel_rd;
    logic [WORD_SIZE-1:0] sel_data;
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] clr_mask;
    logic [REG_COUNT-1:0] busy_next;

    assign lsu_req     = '{rd: lsu_rd_i, data: lsu_data_i};
    assign lsu_ready_o = !full;
    assign push        = lsu_valid_i && !full;
    assign pop         = !alu_valid_i && !empty;

    wb_fifo #(
        .T     (req_t),
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (lsu_req),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign sel_valid = alu_valid_i || pop;
    assign sel_rd    = alu_valid_i ? alu_rd_i : head.rd;
    assign sel_data  = alu_valid_i ? alu_data_i : head.data;

    // A popped load clears its bit as it lands on the outputs; a same-cycle issue re-arms it
    assign set_mask  = issue_load_i ? REG_COUNT'(1) << issue_rd_i : '0;
    assign clr_mask  = pop ? REG_COUNT'(1) << head.rd : '0;
    assign busy_next = ((busy_o & ~clr_mask) | set_mask) & ~REG_COUNT'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_o  <= 1'b0;
            write_reg_o  <= '0;
            write_data_o <= '0;
            busy_o       <= '0;
        end else begin
            reg_write_o <= sel_valid && sel_rd != '0;
            if (sel_valid) begin
                write_reg_o  <= sel_rd;
                write_data_o <= sel_data;
            end
            busy_o <= busy_next;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus with a write-port scoreboard for reg_writeback
module tb_reg_writeback;
    import riscv_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        alu_valid = 0;
    logic [4:0]  alu_rd = 0;
    logic [31:0] alu_data = 0;
    logic        lsu_valid = 0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = 0;
    logic [31:0] lsu_data = 0;
    logic        issue_load = 0;
    logic [4:0]  issue_rd = 0;
    logic [31:0] busy;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .alu_valid_i  (alu_valid),
        .alu_rd_i     (alu_rd),
        .alu_data_i   (alu_data),
        .lsu_valid_i  (lsu_valid),
        .lsu_ready_o  (lsu_ready),
        .lsu_rd_i     (lsu_rd),
        .lsu_data_i   (lsu_data),
        .issue_load_i (issue_load),
        .issue_rd_i   (issue_rd),
        .busy_o       (busy),
        .reg_write_o  (reg_write),
        .write_reg_o  (write_reg),
        .write_data_o (write_data)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] data, input bit expect_write);
        alu_valid = 1;
        alu_rd    = rd;
        alu_data  = data;
        if (expect_write) exp_q.push_back('{rd: rd, data: data});
    endtask

    task automatic lsu(input logic [4:0] rd, input logic [31:0] data, input bit expect_write);
        lsu_valid = 1;
        lsu_rd    = rd;
        lsu_data  = data;
        if (expect_write) exp_q.push_back('{rd: rd, data: data});
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_load = 1;
        issue_rd   = rd;
    endtask

    // Monitor: every register-file write must match the next expected result
    always @(negedge clk) begin
        if (reg_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", write_reg, write_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 64'(write_reg), 64'(e.rd));
                chk("wb_data", 64'(write_data), 64'(e.data));
            end
        end
        if (alu_valid && alu_rd != 0)
            chk("alu_to_busy_rd", 64'(busy[alu_rd]), 64'(0));
    end

    initial begin
        tick;
        tick;
        rst = 0;
        chk("rst_reg_write", 64'(reg_write), 64'(0));
        chk("rst_write_reg", 64'(write_reg), 64'(0));
        chk("rst_write_data", 64'(write_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(lsu_ready), 64'(1));

        alu(5, 32'hDEADBEEF, 1);
        tick;
        alu_valid = 0;
        chk("t1_reg_write", 64'(reg_write), 64'(1));
        chk("t1_write_reg", 64'(write_reg), 64'(5));
        chk("t1_write_data", 64'(write_data), 64'hDEADBEEF);
        chk("t1_busy", 64'(busy), 64'(0));

        issue(7);
        tick;
        issue_load = 0;
        chk("t2_busy_set", 64'(busy), 64'h80);
        tick;
        tick;
        chk("t2_busy_hold", 64'(busy[7]), 64'(1));
        lsu(7, 32'h12345678, 1);
        chk("t2_ready", 64'(lsu_ready), 64'(1));
        tick;
        lsu_valid = 0;
        chk("t2_busy_pending", 64'(busy[7]), 64'(1));
        chk("t2_no_write_yet", 64'(reg_write), 64'(0));
        tick;
        chk("t2_write", 64'(reg_write), 64'(1));
        chk("t2_write_reg", 64'(write_reg), 64'(7));
        chk("t2_busy_clear", 64'(busy[7]), 64'(0));

        alu(1, 32'hA1, 1);
        lsu(10, 32'hB0, 0);
        chk("t3_ready0", 64'(lsu_ready), 64'(1));
        tick;
        alu(2, 32'hA2, 1);
        lsu(11, 32'hB1, 0);
        chk("t3_ready1", 64'(lsu_ready), 64'(1));
        tick;
        alu(3, 32'hA3, 1);
        lsu(12, 32'hB2, 0);
        chk("t3_full", 64'(lsu_ready), 64'(0));
        tick;
        alu(4, 32'hA4, 1);
        chk("t3_full_alu", 64'(lsu_ready), 64'(0));
        tick;
        alu_valid = 0;
        chk("t3_no_bypass", 64'(lsu_ready), 64'(0));
        exp_q.push_back('{rd: 10, data: 32'hB0});
        exp_q.push_back('{rd: 11, data: 32'hB1});
        exp_q.push_back('{rd: 12, data: 32'hB2});
        tick;
        chk("t3_first_lsu", 64'(write_reg), 64'(10));
        chk("t3_ready_again", 64'(lsu_ready), 64'(1));
        tick;
        lsu_valid = 0;
        chk("t3_second_lsu", 64'(write_reg), 64'(11));
        tick;
        chk("t3_third_lsu", 64'(write_reg), 64'(12));
        tick;
        chk("t3_drained", 64'(reg_write), 64'(0));

        alu(0, 32'hFFFFFFFF, 0);
        tick;
        alu_valid = 0;
        chk("t4_alu_x0_we", 64'(reg_write), 64'(0));
        chk("t4_alu_x0_reg", 64'(write_reg), 64'(0));
        chk("t4_alu_x0_data", 64'(write_data), 64'hFFFFFFFF);
        issue(0);
        lsu(0, 32'h55, 0);
        tick;
        issue_load = 0;
        lsu_valid = 0;
        chk("t4_busy0", 64'(busy), 64'(0));
        tick;
        chk("t4_lsu_x0_we", 64'(reg_write), 64'(0));
        chk("t4_lsu_x0_data", 64'(write_data), 64'h55);
        chk("t4_busy_after", 64'(busy), 64'(0));

        issue(9);
        tick;
        issue_load = 0;
        chk("t5_busy_set", 64'(busy[9]), 64'(1));
        lsu(9, 32'h99, 1);
        tick;
        lsu_valid = 0;
        issue(9);
        tick;
        issue_load = 0;
        chk("t5_write", 64'(reg_write), 64'(1));
        chk("t5_set_wins", 64'(busy[9]), 64'(1));
        lsu(9, 32'h9A, 1);
        tick;
        lsu_valid = 0;
        tick;
        chk("t5_second_write", 64'(write_data), 64'h9A);
        chk("t5_busy_clear", 64'(busy), 64'(0));

        issue(7);
        tick;
        issue(10);
        tick;
        issue_load = 0;
        chk("t6_busy", 64'(busy), 64'h480);
        alu(1, 32'h111, 1);
        lsu(7, 32'h777, 0);
        tick;
        alu(2, 32'h222, 1);
        lsu(10, 32'hAAA, 0);
        tick;
        alu_valid = 0;
        lsu_valid = 0;
        chk("t6_full", 64'(lsu_ready), 64'(0));
        chk("t6_busy_pre", 64'(busy), 64'h480);
        rst = 1;
        tick;
        rst = 0;
        chk("t6_busy_rst", 64'(busy), 64'(0));
        chk("t6_ready_rst", 64'(lsu_ready), 64'(1));
        chk("t6_no_write0", 64'(reg_write), 64'(0));
        tick;
        chk("t6_no_write1", 64'(reg_write), 64'(0));
        tick;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
